// File: rtl/spi_tx_sched.sv
// Transmit scheduler for the SDIO SPI-mode slave: round-robin, frame-held grants onto
// the shared byte shifter, with fill bytes whenever no frame byte is available.
module spi_tx_sched #(
    parameter int unsigned NREQ      = 3,
    parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
    input  logic                SPI_Clk,
    input  logic                SPI_ResetN,
    input  logic                Abort,
    input  logic [NREQ-1:0]     Req,
    input  logic [NREQ-1:0]     Last,
    input  logic [8*NREQ-1:0]   Data,
    output logic [NREQ-1:0]     Pop,
    output logic [NREQ-1:0]     Gnt,
    output logic                Underrun,
    input  logic                Sh_RdyN,
    output logic                Sh_DataRdyN,
    output logic [7:0]          Sh_Data
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RDY
    } state_t;

    state_t            state, stateNxt;
    logic [IdxW-1:0]   gntIdx, gntIdxNxt;
    logic [IdxW-1:0]   rrPtr, rrPtrNxt;
    logic              staleWin, staleWinNxt;
    logic [NREQ-1:0]   popNxt, gntNxt;
    logic              underrunNxt, shDataRdyNNxt;
    logic [7:0]        shDataNxt;

    logic [IdxW-1:0]   arbIdx, cand;
    logic              arbHit;
    logic              winOpen;

    // A window that was live when a frame was aborted must not carry a byte.
    assign winOpen = !Sh_RdyN && !staleWin;

    // Round-robin search starting at rrPtr, ascending with wrap.
    always_comb begin
        arbIdx = rrPtr;
        arbHit = 1'b0;
        cand   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IdxW'((32'(rrPtr) + i) % NREQ);
            if (!arbHit && Req[cand]) begin
                arbHit = 1'b1;
                arbIdx = cand;
            end
        end
    end

    always_ff @(posedge SPI_Clk or negedge SPI_ResetN) begin
        if (!SPI_ResetN) begin
            state       <= IDLE;
            gntIdx      <= '0;
            rrPtr       <= '0;
            staleWin    <= 1'b0;
            Pop         <= '0;
            Gnt         <= '0;
            Underrun    <= 1'b0;
            Sh_DataRdyN <= 1'b1;
            Sh_Data     <= FILL_BYTE;
        end else begin
            state       <= stateNxt;
            gntIdx      <= gntIdxNxt;
            rrPtr       <= rrPtrNxt;
            staleWin    <= staleWinNxt;
            Pop         <= popNxt;
            Gnt         <= gntNxt;
            Underrun    <= underrunNxt;
            Sh_DataRdyN <= shDataRdyNNxt;
            Sh_Data     <= shDataNxt;
        end
    end

    always_comb begin
        stateNxt      = state;
        gntIdxNxt     = gntIdx;
        rrPtrNxt      = rrPtr;
        staleWinNxt   = staleWin && !Sh_RdyN;
        popNxt        = '0;
        gntNxt        = Gnt;
        underrunNxt   = 1'b0;
        shDataRdyNNxt = 1'b1;
        shDataNxt     = Sh_Data;

        if (Abort) begin
            stateNxt    = IDLE;
            gntNxt      = '0;
            staleWinNxt = !Sh_RdyN;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arbHit) begin
                        gntNxt    = NREQ'(1) << arbIdx;
                        gntIdxNxt = arbIdx;
                        stateNxt  = SEND;
                    end else if (winOpen) begin
                        shDataRdyNNxt = 1'b0;
                        shDataNxt     = FILL_BYTE;
                        stateNxt      = WAIT_RDY;
                    end
                end
                SEND: begin
                    if (winOpen) begin
                        shDataRdyNNxt = 1'b0;
                        stateNxt      = WAIT_RDY;
                        if (Req[gntIdx]) begin
                            shDataNxt      = Data[{gntIdx, 3'b000} +: 8];
                            popNxt[gntIdx] = 1'b1;
                            if (Last[gntIdx]) begin
                                gntNxt   = '0;
                                rrPtrNxt = IdxW'((32'(gntIdx) + 1) % NREQ);
                            end
                        end else begin
                            shDataNxt   = FILL_BYTE;
                            underrunNxt = 1'b1;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (Sh_RdyN) begin
                        stateNxt = (|Gnt) ? SEND : IDLE;
                    end
                end
                default: stateNxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx_sched.sv
// Directed self-checking bench for spi_tx_sched: frames, round-robin, fill, underrun,
// abort and asynchronous reset, with the shifter ready windows driven by hand.
module tb_spi_tx_sched;

    localparam int unsigned NREQ = 3;

    logic              SPI_Clk;
    logic              SPI_ResetN;
    logic              Abort;
    logic [NREQ-1:0]   Req;
    logic [NREQ-1:0]   Last;
    logic [8*NREQ-1:0] Data;
    logic [NREQ-1:0]   Pop;
    logic [NREQ-1:0]   Gnt;
    logic              Underrun;
    logic              Sh_RdyN;
    logic              Sh_DataRdyN;
    logic [7:0]        Sh_Data;

    logic [7:0]        lane0, lane1, lane2;
    int                nAssert;
    int                nFail;

    assign Data = {lane2, lane1, lane0};

    spi_tx_sched #(.NREQ(NREQ), .FILL_BYTE(8'hFF)) dut (
        .SPI_Clk     (SPI_Clk),
        .SPI_ResetN  (SPI_ResetN),
        .Abort       (Abort),
        .Req         (Req),
        .Last        (Last),
        .Data        (Data),
        .Pop         (Pop),
        .Gnt         (Gnt),
        .Underrun    (Underrun),
        .Sh_RdyN     (Sh_RdyN),
        .Sh_DataRdyN (Sh_DataRdyN),
        .Sh_Data     (Sh_Data)
    );

    initial SPI_Clk = 1'b0;
    always #5 SPI_Clk = ~SPI_Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nAssert++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge SPI_Clk);
        #1;
    endtask

    // Open a ready window; the handoff edge is the first one that samples it low.
    task automatic winOpen(input string tag, input logic [7:0] expData,
                           input logic [NREQ-1:0] expPop, input logic expUnd);
        Sh_RdyN = 1'b0;
        tick();
        check({tag, "/ldn"},  32'(Sh_DataRdyN), 32'(0));
        check({tag, "/data"}, 32'(Sh_Data),     32'(expData));
        check({tag, "/pop"},  32'(Pop),         32'(expPop));
        check({tag, "/und"},  32'(Underrun),    32'(expUnd));
    endtask

    // Second low cycle of the window must not hand off again, then close it.
    task automatic winClose(input string tag);
        tick();
        check({tag, "/ldn1"}, 32'(Sh_DataRdyN), 32'(1));
        check({tag, "/pop0"}, 32'(Pop),         32'(0));
        check({tag, "/und0"}, 32'(Underrun),    32'(0));
        Sh_RdyN = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        nAssert    = 0;
        nFail      = 0;
        SPI_ResetN = 1'b0;
        Abort      = 1'b0;
        Req        = '0;
        Last       = '0;
        lane0      = 8'h00;
        lane1      = 8'h00;
        lane2      = 8'h00;
        Sh_RdyN    = 1'b1;
        tick();
        tick();
        check("rst/ldn",  32'(Sh_DataRdyN), 32'(1));
        check("rst/data", 32'(Sh_Data),     32'hFF);
        check("rst/pop",  32'(Pop),         32'(0));
        check("rst/gnt",  32'(Gnt),         32'(0));
        check("rst/und",  32'(Underrun),    32'(0));
        SPI_ResetN = 1'b1;
        tick();

        // Round-robin from rr_ptr=0: source 0 frame, then source 2 frame
        Req = 3'b101; lane0 = 8'hA1; lane2 = 8'hC1;
        tick();
        check("rr/gnt0", 32'(Gnt), 32'(1));
        winOpen("rr/a1", 8'hA1, 3'b001, 1'b0);
        lane0 = 8'hA2; Last = 3'b001;
        winClose("rr/a1");
        winOpen("rr/a2", 8'hA2, 3'b001, 1'b0);
        check("rr/gnt0end", 32'(Gnt), 32'(0));
        Req = 3'b100; Last = 3'b000;
        winClose("rr/a2");
        check("rr/gnt2", 32'(Gnt), 32'(4));
        winOpen("rr/c1", 8'hC1, 3'b100, 1'b0);
        lane2 = 8'hC2; Last = 3'b100;
        winClose("rr/c1");
        winOpen("rr/c2", 8'hC2, 3'b100, 1'b0);
        Req = 3'b000; Last = 3'b000;
        winClose("rr/c2");
        check("rr/gntend", 32'(Gnt), 32'(0));

        // Idle fill over four windows
        for (int i = 0; i < 4; i++) begin
            winOpen("fill", 8'hFF, 3'b000, 1'b0);
            winClose("fill");
        end
        check("fill/gnt", 32'(Gnt), 32'(0));

        // Underrun mid-frame on source 0 (rr_ptr=0)
        Req = 3'b001; lane0 = 8'h11;
        tick();
        check("und/gnt", 32'(Gnt), 32'(1));
        winOpen("und/b1", 8'h11, 3'b001, 1'b0);
        lane0 = 8'h22; Req = 3'b000;
        winClose("und/b1");
        winOpen("und/gap", 8'hFF, 3'b000, 1'b1);
        check("und/gntkept", 32'(Gnt), 32'(1));
        Req = 3'b001;
        winClose("und/gap");
        winOpen("und/b2", 8'h22, 3'b001, 1'b0);
        lane0 = 8'h33; Last = 3'b001;
        winClose("und/b2");
        winOpen("und/b3", 8'h33, 3'b001, 1'b0);
        Req = 3'b000; Last = 3'b000;
        winClose("und/b3");

        // rr_ptr=1 with sources 0 and 1 requesting: 1 wins (48 00 95)
        Req = 3'b011; lane0 = 8'h5A; lane1 = 8'h48;
        tick();
        check("rr1/gnt", 32'(Gnt), 32'(2));
        winOpen("f1/b1", 8'h48, 3'b010, 1'b0);
        lane1 = 8'h00;
        winClose("f1/b1");
        winOpen("f1/b2", 8'h00, 3'b010, 1'b0);
        lane1 = 8'h95; Last = 3'b010;
        winClose("f1/b2");
        winOpen("f1/b3", 8'h95, 3'b010, 1'b0);
        check("f1/gntend", 32'(Gnt), 32'(0));
        Req = 3'b001; Last = 3'b000;
        winClose("f1/b3");
        check("ab/gnt", 32'(Gnt), 32'(1));

        // Abort in the same cycle a window opens, mid-frame of source 0
        winOpen("ab/b1", 8'h5A, 3'b001, 1'b0);
        lane0 = 8'h5B;
        winClose("ab/b1");
        Abort = 1'b1; Sh_RdyN = 1'b0;
        tick();
        check("ab/ldn",  32'(Sh_DataRdyN), 32'(1));
        check("ab/pop",  32'(Pop),         32'(0));
        check("ab/gnt0", 32'(Gnt),         32'(0));
        check("ab/hold", 32'(Sh_Data),     32'h5A);
        Abort = 1'b0; Req = 3'b000;
        tick();
        check("ab/stale", 32'(Sh_DataRdyN), 32'(1));
        Sh_RdyN = 1'b1;
        tick();
        winOpen("ab/fill", 8'hFF, 3'b000, 1'b0);
        winClose("ab/fill");

        // rr_ptr still 2 after the abort: source 0 beats source 1
        Req = 3'b011; lane0 = 8'h61; lane1 = 8'h71; Last = 3'b011;
        tick();
        check("abrr/gnt", 32'(Gnt), 32'(1));
        winOpen("abrr/f0", 8'h61, 3'b001, 1'b0);
        Req = 3'b010;
        winClose("abrr/f0");
        check("abrr/gnt1", 32'(Gnt), 32'(2));
        winOpen("abrr/f1", 8'h71, 3'b010, 1'b0);
        Req = 3'b000; Last = 3'b000;
        winClose("abrr/f1");

        // Asynchronous reset between two handoffs of a frame
        Req = 3'b001; lane0 = 8'h81;
        tick();
        check("ar/gnt", 32'(Gnt), 32'(1));
        winOpen("ar/b1", 8'h81, 3'b001, 1'b0);
        lane0 = 8'h82;
        winClose("ar/b1");
        #3;
        SPI_ResetN = 1'b0; Req = 3'b000;
        #1;
        check("ar/gnt0", 32'(Gnt),         32'(0));
        check("ar/data", 32'(Sh_Data),     32'hFF);
        check("ar/ldn",  32'(Sh_DataRdyN), 32'(1));
        check("ar/pop",  32'(Pop),         32'(0));
        check("ar/und",  32'(Underrun),    32'(0));
        tick();
        SPI_ResetN = 1'b1;
        tick();
        winOpen("ar/fill", 8'hFF, 3'b000, 1'b0);
        winClose("ar/fill");

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
